// File: rtl/aclock_pkg.sv
// Shared types and constants for the aclock front-panel controller.
package aclock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EDIT_H,
    ST_EDIT_M,
    ST_COMMIT
  } state_e;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } hhmm_t;

  localparam logic [6:0] HOUR_MAX = 7'd23;
  localparam logic [6:0] MIN_MAX  = 7'd59;

  function automatic logic [6:0] bcd2bin(input logic [3:0] tens, input logic [3:0] ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

endpackage

// File: rtl/bcd_hhmm_add.sv
// Combinational BCD HH:MM adder: adds 0..59 minutes (optional carry into hours)
// or increments the hours field alone; hours wrap 23 -> 00.
module bcd_hhmm_add
  import aclock_pkg::*;
(
  input  hhmm_t      a_i,
  input  logic [5:0] add_min_i,
  input  logic       hour_only_i,
  input  logic       carry_en_i,
  output hhmm_t      y_o
);

  logic [6:0] h_bin;
  logic [6:0] m_bin;
  logic [6:0] m_sum;
  logic [6:0] h_nxt;
  logic [6:0] m_nxt;
  logic       wrap;
  logic       h_inc;

  always_comb begin
    h_bin = bcd2bin({2'b00, a_i.h1}, a_i.h0);
    m_bin = bcd2bin(a_i.m1, a_i.m0);
    m_sum = m_bin + 7'(add_min_i);
    wrap  = m_sum > MIN_MAX;
    m_nxt = hour_only_i ? m_bin : (wrap ? m_sum - 7'd60 : m_sum);
    h_inc = hour_only_i | (wrap & carry_en_i);
    h_nxt = !h_inc ? h_bin : ((h_bin >= HOUR_MAX) ? 7'd0 : h_bin + 7'd1);
    y_o.h1 = 2'(h_nxt / 7'd10);
    y_o.h0 = 4'(h_nxt % 7'd10);
    y_o.m1 = 4'(m_nxt / 7'd10);
    y_o.m0 = 4'(m_nxt % 7'd10);
  end

endmodule

// File: rtl/aclock_set_ctrl.sv
// Front-panel edit controller for aclock: time/alarm edit sessions, load strobes,
// AL_ON / STOP_al. Optional snooze on btn_inc is enabled by ACLOCK_SNOOZE_EN.
module aclock_set_ctrl
  import aclock_pkg::*;
#(
  parameter int TIMEOUT_CYC = 600,
  parameter int SNOOZE_MIN  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_set,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_alarm,
  input  logic       alarm_in,
  input  logic [1:0] cur_H1,
  input  logic [3:0] cur_H0,
  input  logic [3:0] cur_M1,
  input  logic [3:0] cur_M0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       AL_ON,
  output logic       STOP_al,
  output logic       edit_active,
  output logic       edit_field,
  output logic       edit_is_alarm
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_e        state_q, state_d;
  hhmm_t         edit_q, edit_d;
  hhmm_t         shadow_q, shadow_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          target_q, target_d;
  logic          al_on_q, al_on_d;
  logic          stop_q, stop_d;
  logic          ld_time_q, ld_time_d;
  logic          ld_alarm_q, ld_alarm_d;

  hhmm_t      add_a;
  hhmm_t      add_y;
  logic [5:0] add_min;
  logic       hour_only;
  logic       carry_en;
  logic       any_btn;

  bcd_hhmm_add u_add (
    .a_i        (add_a),
    .add_min_i  (add_min),
    .hour_only_i(hour_only),
    .carry_en_i (carry_en),
    .y_o        (add_y)
  );

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d    = state_q;
    edit_d     = edit_q;
    shadow_d   = shadow_q;
    tmo_d      = tmo_q;
    target_d   = target_q;
    al_on_d    = al_on_q;
    stop_d     = 1'b0;
    ld_time_d  = 1'b0;
    ld_alarm_d = 1'b0;
    add_a      = edit_q;
    add_min    = 6'd1;
    hour_only  = 1'b0;
    carry_en   = 1'b0;
    any_btn    = btn_set | btn_mode | btn_inc | btn_alarm;

    case (state_q)
      ST_IDLE: begin
        // Adder is parked on the snooze sum so the IDLE path only has to select it.
        add_a    = shadow_q;
        add_min  = 6'(SNOOZE_MIN);
        carry_en = 1'b1;
        if (btn_mode) begin
          state_d  = ST_EDIT_H;
          target_d = 1'b1;
          edit_d   = shadow_q;
          tmo_d    = '0;
        end else if (btn_set) begin
          state_d  = ST_EDIT_H;
          target_d = 1'b0;
          edit_d   = {cur_H1, cur_H0, cur_M1, cur_M0};
          tmo_d    = '0;
        end
`ifdef ACLOCK_SNOOZE_EN
        else if (btn_inc && alarm_in) begin
          stop_d   = 1'b1;
          target_d = 1'b1;
          edit_d   = add_y;
          state_d  = ST_COMMIT;
        end
`endif
      end
      ST_EDIT_H, ST_EDIT_M: begin
        hour_only = (state_q == ST_EDIT_H);
        if (btn_mode)     state_d = ST_IDLE;
        else if (btn_set) state_d = (state_q == ST_EDIT_H) ? ST_EDIT_M : ST_COMMIT;
        else if (btn_inc) edit_d  = add_y;

        if (any_btn)                tmo_d   = '0;
        else if (tmo_q == TMO_LAST) state_d = ST_IDLE;
        else                        tmo_d   = tmo_q + 1'b1;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (target_q) begin
          ld_alarm_d = 1'b1;
          shadow_d   = edit_q;
        end else begin
          ld_time_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (btn_alarm) begin
      if (alarm_in) stop_d  = 1'b1;
      else          al_on_d = ~al_on_q;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the edit and shadow registers are reset too, because they drive
    // H_in*/M_in* directly and must read 00:00 out of reset.
    if (!reset) begin
      state_q    <= ST_IDLE;
      edit_q     <= '0;
      shadow_q   <= '0;
      tmo_q      <= '0;
      target_q   <= 1'b0;
      al_on_q    <= 1'b0;
      stop_q     <= 1'b0;
      ld_time_q  <= 1'b0;
      ld_alarm_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      edit_q     <= edit_d;
      shadow_q   <= shadow_d;
      tmo_q      <= tmo_d;
      target_q   <= target_d;
      al_on_q    <= al_on_d;
      stop_q     <= stop_d;
      ld_time_q  <= ld_time_d;
      ld_alarm_q <= ld_alarm_d;
    end
  end

  assign H_in1         = edit_q.h1;
  assign H_in0         = edit_q.h0;
  assign M_in1         = edit_q.m1;
  assign M_in0         = edit_q.m0;
  assign LD_time       = ld_time_q;
  assign LD_alarm      = ld_alarm_q;
  assign AL_ON         = al_on_q;
  assign STOP_al       = stop_q;
  assign edit_active   = (state_q == ST_EDIT_H) || (state_q == ST_EDIT_M);
  assign edit_field    = (state_q == ST_EDIT_M);
  assign edit_is_alarm = target_q;

endmodule

// File: tb/tb_aclock_set_ctrl.sv
// Directed self-checking bench for aclock_set_ctrl; snooze expectations follow ACLOCK_SNOOZE_EN.
module tb_aclock_set_ctrl;

  localparam int TMO = 600;
  localparam logic [3:0] B_SET  = 4'b1000;
  localparam logic [3:0] B_MODE = 4'b0100;
  localparam logic [3:0] B_INC  = 4'b0010;
  localparam logic [3:0] B_AL   = 4'b0001;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_set, btn_mode, btn_inc, btn_alarm, alarm_in;
  logic [1:0] cur_H1;
  logic [3:0] cur_H0, cur_M1, cur_M0;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, AL_ON, STOP_al, edit_active, edit_field, edit_is_alarm;
  logic [13:0] data_o;

  int n_chk = 0;
  int n_pass = 0;
  int n_ld_time = 0;
  int n_ld_alarm = 0;
  int n_both = 0;
  logic [13:0] ld_data = '0;
  int base_t, base_a;

  always #5 clk = ~clk;

  aclock_set_ctrl #(.TIMEOUT_CYC(TMO), .SNOOZE_MIN(5)) dut (
    .clk(clk), .reset(reset),
    .btn_set(btn_set), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_alarm(btn_alarm),
    .alarm_in(alarm_in),
    .cur_H1(cur_H1), .cur_H0(cur_H0), .cur_M1(cur_M1), .cur_M0(cur_M0),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .AL_ON(AL_ON), .STOP_al(STOP_al),
    .edit_active(edit_active), .edit_field(edit_field), .edit_is_alarm(edit_is_alarm)
  );

  assign data_o = {H_in1, H_in0, M_in1, M_in0};

  always @(negedge clk) begin
    if (LD_time)             n_ld_time  <= n_ld_time + 1;
    if (LD_alarm)            n_ld_alarm <= n_ld_alarm + 1;
    if (LD_time && LD_alarm) n_both     <= n_both + 1;
    if (LD_time || LD_alarm) ld_data    <= data_o;
  end

  function automatic logic [13:0] hm(input int h, input int m);
    return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] b);
    {btn_set, btn_mode, btn_inc, btn_alarm} = b;
    step();
    {btn_set, btn_mode, btn_inc, btn_alarm} = 4'b0000;
  endtask

  task automatic mark();
    base_t = n_ld_time;
    base_a = n_ld_alarm;
  endtask

  initial begin
    reset = 1'b0;
    {btn_set, btn_mode, btn_inc, btn_alarm} = 4'b0000;
    alarm_in = 1'b0;
    {cur_H1, cur_H0, cur_M1, cur_M0} = hm(12, 34);
    repeat (2) step();
    check("reset_outputs", {data_o, LD_time, LD_alarm, AL_ON, STOP_al, edit_active,
                            edit_field, edit_is_alarm}, 0);
    reset = 1'b1;
    step();

    // 1: time edit 12:34 -> 14:37
    mark();
    press(B_SET);
    check("t1_edit_h_flags", {edit_active, edit_field, edit_is_alarm}, 3'b100);
    check("t1_seed", data_o, hm(12, 34));
    repeat (2) press(B_INC);
    press(B_SET);
    check("t1_edit_m_flags", {edit_active, edit_field, edit_is_alarm}, 3'b110);
    check("t1_hours", data_o, hm(14, 34));
    repeat (3) press(B_INC);
    check("t1_minutes", data_o, hm(14, 37));
    press(B_SET);
    repeat (3) step();
    check("t1_ld_time_cnt", n_ld_time - base_t, 1);
    check("t1_ld_alarm_cnt", n_ld_alarm - base_a, 0);
    check("t1_ld_data", ld_data, hm(14, 37));
    check("t1_idle", edit_active, 0);

    // 2: alarm edit from shadow 00:00, hour and minute wrap
    mark();
    press(B_MODE);
    check("t2_flags", {edit_active, edit_field, edit_is_alarm}, 3'b101);
    check("t2_seed", data_o, hm(0, 0));
    repeat (23) press(B_INC);
    check("t2_h23", data_o, hm(23, 0));
    press(B_INC);
    check("t2_h_wrap", data_o, hm(0, 0));
    press(B_SET);
    repeat (59) press(B_INC);
    check("t2_m59", data_o, hm(0, 59));
    press(B_INC);
    check("t2_m_wrap_no_carry", data_o, hm(0, 0));
    press(B_SET);
    repeat (3) step();
    check("t2_ld_alarm_cnt", n_ld_alarm - base_a, 1);
    check("t2_ld_time_cnt", n_ld_time - base_t, 0);
    check("t2_ld_data", ld_data, hm(0, 0));

    // load shadow with 07:02
    mark();
    press(B_MODE);
    repeat (7) press(B_INC);
    press(B_SET);
    repeat (2) press(B_INC);
    press(B_SET);
    repeat (3) step();
    check("t2b_ld_alarm_cnt", n_ld_alarm - base_a, 1);
    check("t2b_ld_data", ld_data, hm(7, 2));

    // 3: cancel and timeout
    mark();
    press(B_MODE);
    check("t3_shadow_seed", data_o, hm(7, 2));
    press(B_INC);
    press(B_SET);
    press(B_MODE);
    step();
    check("t3_cancel_idle", edit_active, 0);
    press(B_MODE);
    check("t3_shadow_kept", data_o, hm(7, 2));
    repeat (TMO - 1) step();
    press(B_INC);
    check("t3_pre_timeout", edit_active, 1);
    check("t3_pre_timeout_data", data_o, hm(8, 2));
    repeat (TMO - 1) step();
    check("t3_one_short", edit_active, 1);
    step();
    check("t3_timeout", edit_active, 0);
    repeat (2) step();
    check("t3_no_strobes", (n_ld_time - base_t) + (n_ld_alarm - base_a), 0);
    press(B_MODE);
    check("t3_shadow_after_tmo", data_o, hm(7, 2));
    press(B_MODE);

    // 4: AL_ON toggle and alarm stop
    check("t4_al_on_init", AL_ON, 0);
    press(B_AL);
    check("t4_al_on_set", {AL_ON, STOP_al}, 2'b10);
    alarm_in = 1'b1;
    press(B_AL);
    check("t4_stop_pulse", {AL_ON, STOP_al}, 2'b11);
    step();
    check("t4_stop_one_cycle", {AL_ON, STOP_al}, 2'b10);
    alarm_in = 1'b0;

    // 6: snooze from shadow 23:58
    mark();
    press(B_MODE);
    repeat (16) press(B_INC);
    press(B_SET);
    repeat (56) press(B_INC);
    press(B_SET);
    repeat (3) step();
    check("t6_shadow_2358", ld_data, hm(23, 58));
    alarm_in = 1'b1;
    mark();
    press(B_INC);
`ifdef ACLOCK_SNOOZE_EN
    check("t6_stop", {STOP_al, LD_alarm}, 2'b10);
    step();
    check("t6_ld_alarm", {STOP_al, LD_alarm}, 2'b01);
    check("t6_snooze_data", data_o, hm(0, 3));
    step();
    check("t6_ld_one_cycle", n_ld_alarm - base_a, 1);
`else
    check("t6_no_stop", STOP_al, 0);
    repeat (2) step();
    check("t6_no_ld_alarm", n_ld_alarm - base_a, 0);
    check("t6_still_idle", edit_active, 0);
`endif
    check("t6_al_on_kept", AL_ON, 1);
    alarm_in = 1'b0;

    // 5: reset in the EDIT_M cycle where btn_set arrives
    press(B_SET);
    press(B_SET);
    check("t5_in_edit_m", {edit_active, edit_field}, 2'b11);
    mark();
    btn_set = 1'b1;
    reset = 1'b0;
    #2;
    check("t5_reset_outputs", {data_o, LD_time, LD_alarm, AL_ON, STOP_al, edit_active,
                               edit_field, edit_is_alarm}, 0);
    @(posedge clk);
    #1;
    btn_set = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    check("t5_no_strobe", (n_ld_time - base_t) + (n_ld_alarm - base_a), 0);
    check("t5_idle", {edit_active, AL_ON}, 2'b00);

    check("no_ld_overlap", n_both, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
